// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor: counts spikes over fixed windows of WINDOW clk cycles.
// At the end of each window it presents the spike count (rate) and the most
// recent inter-spike interval (isi) on a valid/ready result port.
// A result that completes while the previous one is still unaccepted is
// dropped and the sticky overrun flag is raised.
// Optional feature macro: SPIKE_RATE_MONITOR_ISI_EN. When it is defined, the
// gap counter and ISI register are built. When it is undefined, isi is tied to 0.
module spike_rate_monitor #(
    parameter int WINDOW = 100,  // window length in cycles, 2..255
    parameter int CNT_W  = 8     // width of the spike-count result
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] rate,
    output logic [7:0]       isi,
    output logic             overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [7:0]       LAST_IDX = 8'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       win_cnt;
    logic [7:0]       win_cnt_nxt;
    logic [CNT_W-1:0] spk_cnt;
    logic [CNT_W-1:0] spk_cnt_nxt;
    logic [CNT_W-1:0] spk_sum;
    logic             counting;
    logic             win_end;
    logic             load;
    logic             drop;

    assign counting = (state == COUNT);
    assign win_end  = counting && (win_cnt == LAST_IDX);

    // A finished window loads only if the result slot is empty or is being
    // emptied on this same edge; otherwise the new result is lost.
    assign load = win_end && (!out_valid || out_ready);
    assign drop = win_end && out_valid && !out_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of all the others.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is evaluated only on the clock edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: enable alone moves between IDLE and COUNT.
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = COUNT;
            COUNT:   if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window and spike counters. Both are held at zero unless the FSM stays
    // in COUNT. As a result, leaving COUNT discards a partial window, and the
    // first COUNT cycle is always window index 0.
    always_comb begin
        spk_sum     = (spk_cnt == CNT_MAX) ? spk_cnt : spk_cnt + CNT_W'(spike);
        win_cnt_nxt = '0;
        spk_cnt_nxt = '0;
        if (counting && (state_nxt == COUNT) && !win_end) begin
            win_cnt_nxt = win_cnt + 8'd1;
            spk_cnt_nxt = spk_sum;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
            spk_cnt <= '0;
        end else begin
            win_cnt <= win_cnt_nxt;
            spk_cnt <= spk_cnt_nxt;
        end
    end

    // Result slot: load a finished window, release it on transfer, and
    // flag a dropped window. The overrun flag is cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            rate      <= '0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                rate      <= spk_sum;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef SPIKE_RATE_MONITOR_ISI_EN
    logic [7:0] gap_cnt;
    logic [7:0] gap_cnt_nxt;
    logic [7:0] isi_reg;
    logic [7:0] isi_reg_nxt;
    logic [7:0] spike_isi;
    logic [7:0] isi_result;
    logic       seen;
    logic       seen_nxt;

    // Gap tracking. The gap counter runs every COUNT cycle and saturates.
    // A spike latches the gap and restarts the counter at 1.
    // The seen flag makes the first spike after entering COUNT report 0.
    // All ISI state is cleared whenever COUNT is left.
    always_comb begin
        spike_isi   = seen ? gap_cnt : 8'd0;
        gap_cnt_nxt = '0;
        isi_reg_nxt = '0;
        seen_nxt    = 1'b0;
        if (counting && (state_nxt == COUNT)) begin
            if (spike) begin
                isi_reg_nxt = spike_isi;
                gap_cnt_nxt = 8'd1;
                seen_nxt    = 1'b1;
            end else begin
                isi_reg_nxt = isi_reg;
                gap_cnt_nxt = (gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1;
                seen_nxt    = seen;
            end
        end
        // A spike on the window's last cycle is part of that window's result.
        isi_result = spike ? spike_isi : isi_reg;
    end

    // ISI tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
            isi_reg <= '0;
            seen    <= 1'b0;
        end else begin
            gap_cnt <= gap_cnt_nxt;
            isi_reg <= isi_reg_nxt;
            seen    <= seen_nxt;
        end
    end

    // ISI output register; it loads together with rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            isi <= '0;
        end else if (load) begin
            isi <= isi_result;
        end
    end
`else
    assign isi = 8'd0;
`endif

endmodule
